// File: rtl/s27_pkg.sv
// rtl/s27_pkg.sv - shared widths, state bit indices and sequencer states for the s27 scan array
package s27_pkg;

    localparam int STATE_W = 3;
    localparam int G_W     = 4;

    localparam int Q0_IDX = 0;
    localparam int Q1_IDX = 1;
    localparam int Q2_IDX = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } fsm_e;

endpackage

// File: rtl/s27_core.sv
// rtl/s27_core.sv - combinational s27 benchmark logic: next state and G17 from inputs and current state
module s27_core
    import s27_pkg::*;
(
    input  logic [G_W-1:0]     g,
    input  logic [STATE_W-1:0] q,
    output logic [STATE_W-1:0] d,
    output logic               g17
);

    logic g8, g9, g10, g11, g12, g13, g14, g15, g16;

    assign g14 = ~g[0];
    assign g12 = ~(q[Q2_IDX] | g[1]);
    assign g13 = ~(g[2] | g12);
    assign g8  = q[Q1_IDX] & g14;
    assign g15 = g12 | g8;
    assign g16 = g[3] | g8;
    assign g9  = ~(g16 & g15);
    assign g11 = ~(q[Q0_IDX] | g9);
    assign g10 = ~(g14 | g11);

    assign g17         = ~g11;
    assign d[Q0_IDX]   = g10;
    assign d[Q1_IDX]   = g11;
    assign d[Q2_IDX]   = g13;

endmodule

// File: rtl/s27_scan_array.sv
// rtl/s27_scan_array.sv - LANES s27 cores on one full-scan chain with a DEPTH-cycle burst sequencer; optional S27_STATE_OBS_EN adds STATE_OBS/HOLD
module s27_scan_array
    import s27_pkg::*;
#(
    parameter  int LANES = 4,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
`ifdef S27_STATE_OBS_EN
    input  logic                     HOLD,
    output logic [STATE_W*LANES-1:0] STATE_OBS,
`endif
    input  logic                     CK,
    input  logic                     RN,
    input  logic [G_W*LANES-1:0]     G_IN,
    input  logic                     SE,
    input  logic                     SI,
    output logic                     SO,
    input  logic                     START,
    output logic                     BUSY,
    output logic                     DONE,
    output logic [CNT_W-1:0]         CYCLE_CNT,
    output logic [LANES-1:0]         G17
);

    localparam int N = STATE_W * LANES;

    // Lane l occupies st[3l+:3] as {Q2,Q1,Q0}, so the chain is simply st[0] -> st[N-1].
    logic [N-1:0]     st;
    logic [N-1:0]     nxt_st;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic             busy;
    logic             done;
    logic             hold;
    fsm_e             fsm;

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        s27_core u_core (
            .g   (G_IN[G_W*l +: G_W]),
            .q   (st[STATE_W*l +: STATE_W]),
            .d   (nxt_st[STATE_W*l +: STATE_W]),
            .g17 (G17[l])
        );
    end

`ifdef S27_STATE_OBS_EN
    assign hold      = HOLD;
    assign STATE_OBS = st;
`else
    assign hold = 1'b0;
`endif

    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge CK or negedge RN) begin
        if (!RN) begin
            st   <= '0;
            fsm  <= IDLE;
            cnt  <= '0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            case (fsm)
                IDLE: begin
                    done <= 1'b0;
                    // Scan shift outranks START; a START seen together with SE is dropped.
                    if (SE) begin
                        st <= {st[N-2:0], SI};
                    end else if (START) begin
                        fsm  <= RUN;
                        busy <= 1'b1;
                        cnt  <= '0;
                    end
                end
                RUN: begin
                    if (!hold) begin
                        st  <= nxt_st;
                        cnt <= cnt_inc;
                        if (cnt_inc == CNT_W'(DEPTH)) begin
                            fsm  <= FIN;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    done <= 1'b0;
                    fsm  <= IDLE;
                end
                default: begin
                    fsm  <= IDLE;
                    busy <= 1'b0;
                    done <= 1'b0;
                end
            endcase
        end
    end

    assign SO        = st[N-1];
    assign BUSY      = busy;
    assign DONE      = done;
    assign CYCLE_CNT = cnt;

endmodule
